hd44780_sink: RTL and testbench



---
 rtl/hd44780_sink_if.sv | 9 +
 rtl/hd44780_sink.sv | 150 +++++++++++++++
 tb/tb_hd44780_sink.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_sink_if.sv
// HD44780 character-LCD bus between a driver (master) and the receiving sink (slave).
interface hd44780_sink_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic [3:0] lcd_data;

    modport master (output lcd_en, output lcd_rs, output lcd_data);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_data);
endinterface

// File: rtl/hd44780_sink.sv
// HD44780 bus receiver: strobe capture, 8/4-bit byte assembly, instruction decode
// and a 2x16 character buffer with a registered read port.
module hd44780_sink #(
    parameter int CLEAR_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    hd44780_sink_if.slave lcd,
    input  logic [4:0]    rd_addr,
    output logic [7:0]    rd_data,
    output logic [6:0]    ac,
    output logic          display_on,
    output logic          four_bit,
    output logic          busy,
    output logic          err,
    output logic          cmd_valid,
    output logic          cmd_rs,
    output logic [7:0]    cmd_byte
);
    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POR   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] clr_cnt;
    logic [CNT_W-1:0] clr_idx;
    logic             clr_wr;
    logic             en_q;
    logic             rs_q;
    logic [3:0]       data_q;
    logic [3:0]       hi_nib;
    logic             inc;
    logic             phase;
    logic             strobe;
    logic             accept;
    logic             first_nib;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic [5:0]       slot;
    logic [7:0]       mem [0:31];

    // Cursor movement across the two 40-character DDRAM lines.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h40) return 7'h27;
        if (a == 7'h00) return 7'h67;
        return a - 7'd1;
    endfunction

    // {stored, index}: only the first 16 columns of each line are kept.
    function automatic logic [5:0] ac_slot(input logic [6:0] a);
        return {(a[5:4] == 2'b00), a[6], a[3:0]};
    endfunction

    assign busy      = (state == ST_CLEAR);
    assign strobe    = en_q && !lcd.lcd_en;
    assign accept    = strobe && (state == ST_IDLE);
    assign first_nib = accept && four_bit && !phase;
    assign byte_done = accept && !(four_bit && !phase);
    assign byte_val  = four_bit ? {hi_nib, data_q} : {data_q, 4'h0};
    assign slot      = ac_slot(ac);
    assign clr_idx   = CLEAR_LOAD - clr_cnt;
    assign clr_wr    = busy && !reset && (clr_idx < CNT_W'(32));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_POR;
            clr_cnt    <= '0;
            en_q       <= 1'b0;
            ac         <= 7'h00;
            display_on <= 1'b0;
            four_bit   <= 1'b0;
            inc        <= 1'b1;
            phase      <= 1'b0;
            err        <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_rs     <= 1'b0;
            cmd_byte   <= 8'h00;
        end else begin
            en_q      <= lcd.lcd_en;
            cmd_valid <= 1'b0;
            if (strobe && busy) err <= 1'b1;

            case (state)
                ST_POR: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= CLEAR_LOAD;
                    ac      <= 7'h00;
                    inc     <= 1'b1;
                end
                ST_CLEAR: begin
                    if (clr_cnt == CNT_W'(1)) state <= ST_IDLE;
                    clr_cnt <= clr_cnt - CNT_W'(1);
                end
                default: ;
            endcase

            if (accept) phase <= first_nib;

            if (byte_done) begin
                cmd_valid <= 1'b1;
                cmd_rs    <= rs_q;
                cmd_byte  <= byte_val;
                if (rs_q) begin
                    ac <= ac_step(ac, inc);
                end else begin
                    casez (byte_val)
                        8'b1???????: ac <= byte_val[6:0];
                        8'b001?????: four_bit <= ~byte_val[4];
                        8'b0001????: if (!byte_val[3]) ac <= ac_step(ac, byte_val[2]);
                        8'b00001???: display_on <= byte_val[2];
                        8'b000001??: inc <= byte_val[1];
                        8'b0000001?: ac <= 7'h00;
                        8'b00000001: begin
                            state   <= ST_CLEAR;
                            clr_cnt <= CLEAR_LOAD;
                            ac      <= 7'h00;
                            inc     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Bus sampling and character storage carry no reset.
    always_ff @(posedge clk) begin
        rs_q   <= lcd.lcd_rs;
        data_q <= lcd.lcd_data;
        if (first_nib) hi_nib <= data_q;
        if (clr_wr) begin
            mem[clr_idx[4:0]] <= 8'h20;
        end else if (byte_done && rs_q && slot[5]) begin
            mem[slot[4:0]] <= byte_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= 8'h00;
        else       rd_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_hd44780_sink.sv
// Randomised bench for hd44780_sink against a line-ring model of the LCD controller.
module tb_hd44780_sink;
    localparam int CLEAR_CYCLES = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       display_on, four_bit, busy, err, cmd_valid, cmd_rs;
    logic [7:0] cmd_byte;

    hd44780_sink_if lcd_bus ();

    hd44780_sink #(.CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd        (lcd_bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ac         (ac),
        .display_on (display_on),
        .four_bit   (four_bit),
        .busy       (busy),
        .err        (err),
        .cmd_valid  (cmd_valid),
        .cmd_rs     (cmd_rs),
        .cmd_byte   (cmd_byte)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Length of the most recent run of busy cycles.
    int busy_run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_run <= busy_run;
            busy_run <= 0;
        end
    end

    logic [7:0] m_buf [32];
    int m_ac, m_hi, m_byte;
    bit m_inc, m_four, m_disp, m_phase, m_err, m_busy, m_valid, m_rs;

    // DDRAM seen as one 80-position ring (line 0 then line 1); other addresses step mod 128.
    function automatic int next_addr(input int a, input bit up);
        int pos;
        if (a < 40) pos = a;
        else if (a >= 64 && a < 104) pos = a - 24;
        else return up ? (a + 1) % 128 : (a + 127) % 128;
        pos = up ? (pos + 1) % 80 : (pos + 79) % 80;
        return (pos < 40) ? pos : pos + 24;
    endfunction

    function automatic int buf_index(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_ac = 0;
        m_inc = 1;
        m_busy = 1;
    endtask

    task automatic model_byte(input bit rs, input int b);
        int idx;
        m_valid = 1; m_byte = b; m_rs = rs;
        if (rs) begin
            idx = buf_index(m_ac);
            if (idx >= 0) m_buf[idx] = 8'(b);
            m_ac = next_addr(m_ac, m_inc);
        end
        else if (b >= 128) m_ac = b - 128;
        else if (b >= 32) m_four = ((b / 16) % 2) == 0;
        else if (b >= 16) begin
            if (((b / 8) % 2) == 0) m_ac = next_addr(m_ac, ((b / 4) % 2) == 1);
        end
        else if (b >= 8) m_disp = ((b / 4) % 2) == 1;
        else if (b >= 4) m_inc = ((b / 2) % 2) == 1;
        else if (b >= 2) m_ac = 0;
        else if (b == 1) model_clear();
    endtask

    task automatic model_strobe(input bit rs, input int nib);
        m_valid = 0;
        if (m_busy) m_err = 1;
        else if (m_four && !m_phase) begin
            m_hi = nib;
            m_phase = 1;
        end else begin
            m_phase = 0;
            model_byte(rs, m_four ? m_hi * 16 + nib : nib * 16);
        end
    endtask

    // Called on a falling clock edge with lcd_en low; returns on a falling edge.
    task automatic strobe(input bit rs, input int nib);
        lcd_bus.lcd_en   = 1'b1;
        lcd_bus.lcd_rs   = rs;
        lcd_bus.lcd_data = 4'(nib);
        @(negedge clk);
        lcd_bus.lcd_en = 1'b0;
        model_strobe(rs, nib);
        @(negedge clk);
        check("cmd_valid", cmd_valid, m_valid);
        if (m_valid) begin
            check("cmd_byte", cmd_byte, m_byte);
            check("cmd_rs", cmd_rs, m_rs);
        end
        check("ac", ac, m_ac);
        check("four_bit", four_bit, m_four);
        check("display_on", display_on, m_disp);
        check("err", err, m_err);
        check("busy", busy, m_busy);
    endtask

    task automatic send4(input bit rs, input int b);
        strobe(rs, b / 16);
        strobe(rs, b % 16);
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!busy && n < 4) begin @(negedge clk); n++; end
        check("busy_rise", busy, 1);
        n = 0;
        while (busy && n < CLEAR_CYCLES + 8) begin @(negedge clk); n++; end
        check("busy_fall", busy, 0);
        #1;
        check("busy_len", last_run, CLEAR_CYCLES);
        m_busy = 0;
        @(negedge clk);
    endtask

    task automatic check_buf();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), rd_data, m_buf[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ac", ac, 0);
        check("rst_display_on", display_on, 0);
        check("rst_four_bit", four_bit, 0);
        check("rst_err", err, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_rs", cmd_rs, 0);
        check("rst_cmd_byte", cmd_byte, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        m_four = 0; m_disp = 0; m_phase = 0; m_err = 0;
        model_clear();
    endtask

    initial begin
        int r, a;
        int edge_addr[8] = '{0, 15, 39, 64, 79, 103, 16, 127};
        reset = 1'b1;
        rd_addr = 5'd0;
        lcd_bus.lcd_en = 1'b0;
        lcd_bus.lcd_rs = 1'b0;
        lcd_bus.lcd_data = 4'h0;

        do_reset();
        wait_clear();

        // Wake-up sequence into 4-bit mode, then standard init.
        strobe(0, 3); strobe(0, 3); strobe(0, 3); strobe(0, 2);
        send4(0, 8'h28); send4(0, 8'h0C); send4(0, 8'h06); send4(0, 8'h01);
        wait_clear();
        check_buf();

        send4(0, 8'hC4); send4(1, 8'h41); send4(1, 8'h42);
        send4(0, 8'hA7); send4(1, 8'h58); send4(1, 8'h59);
        send4(0, 8'h04); send4(0, 8'h80); send4(1, 8'h5A); send4(0, 8'h14);
        check_buf();

        // Strobe landing inside a clear must be dropped without disturbing nibble phase.
        send4(0, 8'h01);
        repeat (4) @(negedge clk);
        strobe(0, 3);
        wait_clear();
        send4(0, 8'h0E); send4(0, 8'hC1); send4(1, 8'h33);

        for (int it = 0; it < 160; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) send4(1, $urandom_range(32, 126));
            else if (r < 60) begin
                a = ($urandom_range(0, 1) == 1) ? edge_addr[$urandom_range(0, 7)] : $urandom_range(0, 127);
                send4(0, 128 + a);
            end
            else if (r < 68) send4(0, 4 + 2 * $urandom_range(0, 1));
            else if (r < 76) send4(0, 16 + 4 * $urandom_range(0, 3));
            else if (r < 82) send4(0, 8 + $urandom_range(0, 7));
            else if (r < 86) send4(0, 2 + $urandom_range(0, 1));
            else if (r < 88) send4(0, 0);
            else if (r < 90) begin send4(0, 1); wait_clear(); end
            else repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        check_buf();

        // Back to 8-bit, then a reset that lands in the middle of the power-on clear.
        send4(0, 8'h38);
        strobe(0, 8);
        strobe(0, 0);
        do_reset();
        repeat (10) @(negedge clk);
        check("mid_clear_busy", busy, 1);
        do_reset();
        wait_clear();
        check_buf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end
endmodule
